instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter PC_W, default 12, program-address width.
REQ-002 SHALL have parameter STACK_D, default 4, return-stack depth.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pm_addr  output  PC_W  program-memory read address.
REQ-006 SHALL have port pm_req  output  1  program-memory read request.
REQ-007 SHALL have port pm_ack  input  1  read data valid this cycle.
REQ-008 SHALL have port pm_rdata  input  16  program-memory read data.
REQ-009 SHALL have port instruction  output  16  issued instruction word, to control LUT.
REQ-010 SHALL have port OP_dk  output  8  instruction[15:8].
REQ-011 SHALL have port OP_s  output  4  instruction[15:12].
REQ-012 SHALL have port dma  output  7  instruction[6:0], direct data address.
REQ-013 SHALL have port operand  output  PC_W  second-word branch target.
REQ-014 SHALL have port instr_valid  output  1  instruction/operand valid for decode.
REQ-015 SHALL have port instr_ready  input  1  decode consumes issued instruction.
REQ-016 SHALL have port pcInMux_ctrl  input  2  next-PC select from control LUT: 00 operand, 01 stack pop, 10 acc_low, 11 PC+1.
REQ-017 SHALL have port acc_low  input  PC_W  accumulator low bits, computed-branch target.
REQ-018 SHALL have port push  input  1  push return address on consume (call).
REQ-019 SHALL have port pc  output  PC_W  current program counter.
REQ-020 SHALL have port stack_err  output  1  sticky overflow/underflow flag.

Function
REQ-021 SHALL implement FSM states FETCH1, FETCH2, ISSUE.
REQ-022 FETCH1: pm_req=1, pm_addr=pc; on pm_ack latch pm_rdata into instruction; if pm_rdata[15:12]==4'hF go FETCH2 with pc<=pc+1, else go ISSUE.
REQ-023 FETCH2: pm_req=1, pm_addr=pc; on pm_ack latch pm_rdata[PC_W-1:0] into operand, go ISSUE.
REQ-024 pm_req SHALL hold high, pm_addr stable, until pm_ack; no-ack cycles leave all state unchanged.
REQ-025 ISSUE: instr_valid=1, pm_req=0; instruction, operand, pc held until instr_ready=1.
REQ-026 On ISSUE with instr_ready=1: pc<=operand (00), stack top (01), acc_low (10), pc+1 (11); state FETCH1; instr_valid low next cycle.
REQ-027 Fetch-to-issue latency SHALL be one cycle after pm_ack of last word; minimum 2 cycles per one-word instruction, 3 per two-word, with pm_ack tied high.
REQ-028 PC arithmetic SHALL be modulo 2^PC_W; {PC_W{1}}+1 wraps to 0, including FETCH2 increment.
REQ-029 Push SHALL write pc+1 (address after last fetched word) to top, shifting entries down; at depth STACK_D oldest entry discarded and stack_err set.
REQ-030 Pop (select 01) SHALL take top as target and shift up; pop on empty yields target 0 and sets stack_err.
REQ-031 push and pop in same consume: target = old top, new top = pushed value, depth unchanged.
REQ-032 push/pcInMux_ctrl SHALL be sampled only on consume cycle; ignored otherwise.
REQ-033 OP_dk, OP_s, dma SHALL be combinational slices of registered instruction.
REQ-034 stack_err SHALL remain set until reset.

Reset
REQ-035 reset_n low SHALL immediately force: pc=0, state FETCH1, instruction=16'h7F80 (NOP), operand=0, instr_valid=0, stack empty, stack_err=0.
REQ-036 pm_req SHALL be 0 while reset_n low and assert on first rising edge after release.
REQ-037 Reset mid-fetch or mid-issue SHALL abandon the transaction; late pm_ack after release ignored unless state FETCH1/FETCH2 and request outstanding.

Verification
REQ-038 Reset release, pm_ack tied 1, memory returns 16'h6A05 at 0 and 16'h0000 at 1 -> instr_valid at cycle 2, OP_dk=8'h6A, dma=7'h05; with instr_ready=1, pc=1 then fetch of address 1.
REQ-039 Word 16'hF900 at 5, 12'h123 at 6, consume with pcInMux_ctrl=00 -> operand=12'h123, pc=12'h123, pm_addr=12'h123 next FETCH1.
REQ-040 pm_ack withheld 4 cycles -> pm_req and pm_addr stable throughout, instr_valid=0; instr_ready=0 in ISSUE 3 cycles -> instruction unchanged.
REQ-041 Five pushes from pc=10,20,30,40,50 -> stack_err=1; four pops return 51,41,31,21; fifth pop returns 0.
REQ-042 pc=12'hFFF one-word instruction, select 11 -> pc=0; pcInMux_ctrl=10, acc_low=12'h0AB -> pc=12'h0AB.
REQ-043 reset_n asserted during FETCH2 -> pc=0, instruction=16'h7F80, instr_valid=0 immediately, no clock edge needed.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Instruction-fetch bus bundle: program-memory read port and decode/issue port.
interface instr_fetch_if #(
  parameter int unsigned PC_W = 12
);
  logic [PC_W-1:0] pm_addr;
  logic            pm_req;
  logic            pm_ack;
  logic [15:0]     pm_rdata;
  logic [15:0]     instruction;
  logic [7:0]      OP_dk;
  logic [3:0]      OP_s;
  logic [6:0]      dma;
  logic [PC_W-1:0] operand;
  logic            instr_valid;
  logic            instr_ready;
  logic [1:0]      pcInMux_ctrl;
  logic [PC_W-1:0] acc_low;
  logic            push;
  logic [PC_W-1:0] pc;
  logic            stack_err;

  modport master (
    output pm_addr, pm_req,
    input  pm_ack, pm_rdata,
    output instruction, OP_dk, OP_s, dma, operand, instr_valid,
    input  instr_ready, pcInMux_ctrl, acc_low, push,
    output pc, stack_err
  );

  modport slave (
    input  pm_addr, pm_req,
    output pm_ack, pm_rdata,
    input  instruction, OP_dk, OP_s, dma, operand, instr_valid,
    output instr_ready, pcInMux_ctrl, acc_low, push,
    input  pc, stack_err
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one/two-word fetch FSM, issue handshake, next-PC
// selection and a fixed-depth return-address stack with sticky error flag.
module instr_fetch #(
  parameter int unsigned PC_W    = 12,
  parameter int unsigned STACK_D = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  instr_fetch_if.master bus
);

  localparam int unsigned DEPTH_W  = $clog2(STACK_D + 1);
  localparam logic [15:0] NOP_WORD = 16'h7F80;
  localparam logic [3:0]  LONG_OP  = 4'hF;

  typedef enum logic [1:0] {FETCH1, FETCH2, ISSUE} state_t;

  state_t             r_state, w_state_nxt;
  logic [PC_W-1:0]    r_pc, w_pc_nxt;
  logic [PC_W-1:0]    r_operand, w_operand_nxt;
  logic [15:0]        r_instr, w_instr_nxt;
  logic               r_pm_req, w_pm_req_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_err, w_err_nxt;
  logic [PC_W-1:0]    r_stack [STACK_D];
  logic [PC_W-1:0]    w_stack_nxt [STACK_D];
  logic [DEPTH_W-1:0] r_depth, w_depth_nxt;

  logic               w_ack;
  logic               w_consume;
  logic               w_pop;
  logic               w_do_push;
  logic               w_empty;
  logic [PC_W-1:0]    w_ret;
  logic [PC_W-1:0]    w_top;

  // Next-state, datapath and return-stack update
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_operand_nxt = r_operand;
    w_instr_nxt   = r_instr;
    w_err_nxt     = r_err;
    w_depth_nxt   = r_depth;
    w_stack_nxt   = r_stack;

    // An ack only counts while our own request is actually on the bus
    w_ack     = r_pm_req & bus.pm_ack;
    w_consume = (r_state == ISSUE) & bus.instr_ready;
    w_pop     = w_consume & (bus.pcInMux_ctrl == 2'b01);
    w_do_push = w_consume & bus.push;
    w_empty   = (r_depth == '0);
    w_ret     = r_pc + PC_W'(1);
    w_top     = w_empty ? '0 : r_stack[0];

    case (r_state)
      FETCH1: begin
        if (w_ack) begin
          w_instr_nxt = bus.pm_rdata;
          if (bus.pm_rdata[15:12] == LONG_OP) begin
            w_state_nxt = FETCH2;
            w_pc_nxt    = r_pc + PC_W'(1);
          end else begin
            w_state_nxt = ISSUE;
          end
        end
      end
      FETCH2: begin
        if (w_ack) begin
          w_operand_nxt = bus.pm_rdata[PC_W-1:0];
          w_state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.instr_ready) begin
          w_state_nxt = FETCH1;
          case (bus.pcInMux_ctrl)
            2'b00:   w_pc_nxt = r_operand;
            2'b01:   w_pc_nxt = w_top;
            2'b10:   w_pc_nxt = bus.acc_low;
            default: w_pc_nxt = w_ret;
          endcase
        end
      end
      default: w_state_nxt = FETCH1;
    endcase

    // Push+pop on a non-empty stack just replaces the top entry
    if (w_do_push && w_pop && !w_empty) begin
      w_stack_nxt[0] = w_ret;
    end else if (w_do_push) begin
      for (int unsigned i = STACK_D - 1; i > 0; i--) begin
        w_stack_nxt[i] = r_stack[i-1];
      end
      w_stack_nxt[0] = w_ret;
      if (r_depth == DEPTH_W'(STACK_D)) begin
        w_err_nxt = 1'b1;
      end else begin
        w_depth_nxt = r_depth + DEPTH_W'(1);
      end
    end else if (w_pop && !w_empty) begin
      for (int unsigned i = 0; i + 1 < STACK_D; i++) begin
        w_stack_nxt[i] = r_stack[i+1];
      end
      w_stack_nxt[STACK_D-1] = '0;
      w_depth_nxt = r_depth - DEPTH_W'(1);
    end

    if (w_pop && w_empty) begin
      w_err_nxt = 1'b1;
    end

    w_pm_req_nxt = (w_state_nxt != ISSUE);
    w_valid_nxt  = (w_state_nxt == ISSUE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= FETCH1;
      r_pc      <= '0;
      r_operand <= '0;
      r_instr   <= NOP_WORD;
      r_pm_req  <= 1'b0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_depth   <= '0;
      for (int unsigned i = 0; i < STACK_D; i++) begin
        r_stack[i] <= '0;
      end
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_operand <= w_operand_nxt;
      r_instr   <= w_instr_nxt;
      r_pm_req  <= w_pm_req_nxt;
      r_valid   <= w_valid_nxt;
      r_err     <= w_err_nxt;
      r_depth   <= w_depth_nxt;
      for (int unsigned i = 0; i < STACK_D; i++) begin
        r_stack[i] <= w_stack_nxt[i];
      end
    end
  end

  assign bus.pm_addr     = r_pc;
  assign bus.pm_req      = r_pm_req;
  assign bus.instruction = r_instr;
  assign bus.OP_dk       = r_instr[15:8];
  assign bus.OP_s        = r_instr[15:12];
  assign bus.dma         = r_instr[6:0];
  assign bus.operand     = r_operand;
  assign bus.instr_valid = r_valid;
  assign bus.pc          = r_pc;
  assign bus.stack_err   = r_err;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: architectural model of program flow and
// return stack predicts every fetch address and every issued instruction.
module tb_instr_fetch;

  localparam int unsigned PC_W    = 12;
  localparam int unsigned STACK_D = 4;
  localparam int unsigned MEM_N   = 1 << PC_W;
  localparam logic [PC_W-1:0] ONE_W [14] = '{
    12'd10, 12'd20, 12'd30, 12'd40, 12'd50, 12'd60, 12'd51,
    12'd41, 12'd31, 12'd21, 12'h123, 12'hFFF, 12'h0AB, 12'hA05
  };

  typedef struct {
    logic [15:0]     instr;
    logic [PC_W-1:0] operand;
    logic [PC_W-1:0] pc;
    logic            err;
  } exp_t;

  logic clk;
  logic reset_n;

  instr_fetch_if #(.PC_W(PC_W)) bus ();

  instr_fetch #(.PC_W(PC_W), .STACK_D(STACK_D)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [15:0]     mem [MEM_N];
  exp_t            exp_q [$];
  logic [PC_W-1:0] fa_q [$];
  logic [PC_W-1:0] m_stack [$];
  logic [PC_W-1:0] m_pc;
  logic [PC_W-1:0] m_operand;
  logic            m_err;
  logic [PC_W-1:0] mon_fa;
  exp_t            cur;

  int          checks    = 0;
  int          failures  = 0;
  bit          sb_en     = 0;
  bit          ack_en    = 0;
  bit          lat_on    = 0;
  bit          after_rst = 0;
  bit          seen      = 0;
  int unsigned ack_pct   = 100;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fill_mem_random();
    logic [15:0] w;
    for (int i = 0; i < int'(MEM_N); i++) begin
      w = 16'($urandom);
      if ($urandom_range(3) == 0) w[15:12] = 4'hF;
      else if (w[15:12] == 4'hF) w[15:12] = 4'h7;
      mem[i] = w;
    end
  endtask

  task automatic model_reset();
    m_pc      = '0;
    m_operand = '0;
    m_err     = 1'b0;
    m_stack.delete();
    exp_q.delete();
    fa_q.delete();
    after_rst = 1'b1;
  endtask

  // Predict one instruction from the model, then play the decode side for it
  task automatic run_instr(input logic [1:0] ctrl, input bit do_push,
                           input logic [PC_W-1:0] acc, input int stall, input int hold);
    exp_t            e;
    logic [15:0]     w0;
    logic [15:0]     w1;
    logic [PC_W-1:0] a0;
    logic [PC_W-1:0] last;
    logic [PC_W-1:0] ret;
    logic [PC_W-1:0] tgt;
    int              words;
    int              n;

    a0 = m_pc;
    w0 = mem[m_pc];
    fa_q.push_back(m_pc);
    last  = m_pc;
    words = 1;
    if (w0[15:12] == 4'hF) begin
      last = m_pc + PC_W'(1);
      fa_q.push_back(last);
      w1 = mem[last];
      m_operand = w1[PC_W-1:0];
      words = 2;
    end
    e.instr   = w0;
    e.operand = m_operand;
    e.pc      = last;
    e.err     = m_err;
    exp_q.push_back(e);

    ret = last + PC_W'(1);
    tgt = '0;
    if (ctrl == 2'b01) begin
      if (m_stack.size() > 0) tgt = m_stack.pop_front();
      else m_err = 1'b1;
    end
    if (do_push) begin
      m_stack.push_front(ret);
      if (m_stack.size() > int'(STACK_D)) begin
        void'(m_stack.pop_back());
        m_err = 1'b1;
      end
    end
    case (ctrl)
      2'b00:   m_pc = m_operand;
      2'b01:   m_pc = tgt;
      2'b10:   m_pc = acc;
      default: m_pc = ret;
    endcase

    if (hold > 0) begin
      ack_en = 1'b0;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk("hold_req", 32'(bus.pm_req), 32'd1);
        chk("hold_addr", 32'(bus.pm_addr), 32'(a0));
        chk("hold_valid", 32'(bus.instr_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      ack_en = 1'b1;
    end

    n = 0;
    while (!bus.instr_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("issue_seen", 32'(bus.instr_valid), 32'd1);
    if (lat_on && hold == 0) chk("latency", 32'(n), 32'(words + (after_rst ? 1 : 0)));
    after_rst = 1'b0;

    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    bus.pcInMux_ctrl = ctrl;
    bus.push         = do_push;
    bus.acc_low      = acc;
    bus.instr_ready  = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_ready  = 1'b0;
    bus.pcInMux_ctrl = 2'($urandom);
    bus.push         = 1'($urandom);
    bus.acc_low      = PC_W'($urandom);
  endtask

  // Program-memory responder
  initial begin
    bus.pm_ack   = 1'b0;
    bus.pm_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.pm_ack   = ack_en && ($urandom_range(99) < ack_pct);
      bus.pm_rdata = bus.pm_ack ? mem[bus.pm_addr] : 16'($urandom);
    end
  end

  // Monitor: fetch addresses and issued instructions against the scoreboard
  always @(negedge clk) begin
    if (!reset_n) begin
      seen = 1'b0;
    end else if (sb_en) begin
      if (bus.pm_req) begin
        chk("valid_in_fetch", 32'(bus.instr_valid), 32'd0);
        if (bus.pm_ack) begin
          if (fa_q.size() == 0) begin
            chk("fetch_unexpected", 32'(bus.pm_addr), 32'hFFFF_FFFF);
          end else begin
            mon_fa = fa_q.pop_front();
            chk("fetch_addr", 32'(bus.pm_addr), 32'(mon_fa));
          end
        end
      end
      if (bus.instr_valid) begin
        if (!seen) begin
          if (exp_q.size() == 0) begin
            chk("issue_unexpected", 32'(bus.instruction), 32'hFFFF_FFFF);
          end else begin
            cur  = exp_q.pop_front();
            seen = 1'b1;
            chk("instruction", 32'(bus.instruction), 32'(cur.instr));
            chk("operand", 32'(bus.operand), 32'(cur.operand));
            chk("issue_pc", 32'(bus.pc), 32'(cur.pc));
            chk("stack_err", 32'(bus.stack_err), 32'(cur.err));
            chk("OP_dk", 32'(bus.OP_dk), 32'(cur.instr[15:8]));
            chk("OP_s", 32'(bus.OP_s), 32'(cur.instr[15:12]));
            chk("dma", 32'(bus.dma), 32'(cur.instr[6:0]));
          end
        end else begin
          chk("hold_instruction", 32'(bus.instruction), 32'(cur.instr));
          chk("hold_pc", 32'(bus.pc), 32'(cur.pc));
        end
        if (bus.instr_ready) seen = 1'b0;
      end
    end
  end

  initial begin
    reset_n          = 1'b1;
    bus.instr_ready  = 1'b0;
    bus.pcInMux_ctrl = 2'b00;
    bus.push         = 1'b0;
    bus.acc_low      = '0;

    fill_mem_random();
    mem[0]      = 16'h6A05;
    mem[1]      = 16'h0000;
    mem[5]      = 16'hF900;
    mem[6]      = 16'h0123;
    mem[12'h200] = 16'hF4C1;
    foreach (ONE_W[k]) mem[ONE_W[k]] = 16'h3000 | 16'(k * 37);

    ack_en  = 1'b1;
    ack_pct = 100;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pm_req", 32'(bus.pm_req), 32'd0);
    chk("rst_pc", 32'(bus.pc), 32'd0);
    chk("rst_pm_addr", 32'(bus.pm_addr), 32'd0);
    chk("rst_instruction", 32'(bus.instruction), 32'h7F80);
    chk("rst_operand", 32'(bus.operand), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_stack_err", 32'(bus.stack_err), 32'd0);

    model_reset();
    lat_on  = 1'b1;
    reset_n = 1'b1;
    chk("release_pm_req", 32'(bus.pm_req), 32'd0);
    sb_en = 1'b1;

    // Directed flow: simple issue, two-word branch, stalls, stack, wrap
    run_instr(2'b11, 1'b0, '0, 0, 0);
    run_instr(2'b10, 1'b0, 12'd5, 0, 0);
    run_instr(2'b00, 1'b0, '0, 0, 0);
    run_instr(2'b10, 1'b0, 12'd10, 3, 4);
    run_instr(2'b10, 1'b1, 12'd20, 0, 0);
    run_instr(2'b10, 1'b1, 12'd30, 0, 0);
    run_instr(2'b10, 1'b1, 12'd40, 0, 0);
    run_instr(2'b10, 1'b1, 12'd50, 0, 0);
    run_instr(2'b10, 1'b1, 12'd60, 0, 0);
    repeat (5) run_instr(2'b01, 1'b0, '0, 0, 0);
    run_instr(2'b10, 1'b0, 12'hFFF, 0, 0);
    run_instr(2'b11, 1'b0, '0, 0, 0);
    run_instr(2'b10, 1'b0, 12'h0AB, 0, 0);
    mem[12'hFFF] = 16'hF123;
    run_instr(2'b10, 1'b0, 12'hFFF, 0, 0);
    run_instr(2'b00, 1'b0, '0, 0, 0);
    run_instr(2'b10, 1'b0, 12'h200, 0, 0);

    // Asynchronous reset while parked in the second-word fetch
    sb_en = 1'b0;
    @(posedge clk);
    #1;
    ack_en = 1'b0;
    #1;
    chk("f2_pc", 32'(bus.pc), 32'(m_pc + PC_W'(1)));
    chk("f2_instruction", 32'(bus.instruction), 32'(mem[m_pc]));
    chk("f2_pm_req", 32'(bus.pm_req), 32'd1);
    chk("f2_valid", 32'(bus.instr_valid), 32'd0);
    chk("f2_stack_err", 32'(bus.stack_err), 32'(m_err));
    #1 reset_n = 1'b0;
    #1;
    chk("arst_pc", 32'(bus.pc), 32'd0);
    chk("arst_instruction", 32'(bus.instruction), 32'h7F80);
    chk("arst_valid", 32'(bus.instr_valid), 32'd0);
    chk("arst_pm_req", 32'(bus.pm_req), 32'd0);
    chk("arst_operand", 32'(bus.operand), 32'd0);
    chk("arst_stack_err", 32'(bus.stack_err), 32'd0);
    fill_mem_random();
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_edge_pm_req", 32'(bus.pm_req), 32'd0);
    reset_n = 1'b1;
    chk("release2_pm_req", 32'(bus.pm_req), 32'd0);
    sb_en  = 1'b1;
    ack_en = 1'b1;
    run_instr(2'b11, 1'b0, '0, 0, 0);

    // Randomized program flow with random memory latency and decode stalls
    lat_on  = 1'b0;
    ack_pct = 70;
    for (int i = 0; i < 150; i++) begin
      run_instr(2'($urandom_range(3)), ($urandom_range(99) < 30),
                PC_W'($urandom), int'($urandom_range(2)), 0);
    end

    sb_en = 1'b0;
    chk("issue_q_drained", 32'(exp_q.size()), 32'd0);
    chk("fetch_q_drained", 32'(fa_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
